// File: rtl/cia_timer_bank.sv
// CIA-style interval timer bank: NUM_TIMERS down-counters with latches, one-shot/continuous
// modes and a masked read-to-clear ICR. Define CIA_TB_CHAIN_EN to enable timer cascading.
module cia_timer_bank #(
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_tick_en,
    input  logic                  i_cs,
    input  logic [3:0]            i_addr,
    input  logic                  i_we,
    input  logic [7:0]            i_data,
    output logic [7:0]            o_data,
    output logic                  o_irq,
    output logic [NUM_TIMERS-1:0] o_underflow
);

    localparam logic [3:0] ICR_ADDR = 4'hD;

    logic [CNT_W-1:0]      cnt_q [NUM_TIMERS];
    logic [CNT_W-1:0]      lat_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] start_q;
    logic [NUM_TIMERS-1:0] oneshot_q;
    logic [NUM_TIMERS-1:0] chain_q;
    logic [NUM_TIMERS-1:0] flag_q;
    logic [NUM_TIMERS-1:0] mask_q;

    logic [NUM_TIMERS-1:0] wr_lo_c;
    logic [NUM_TIMERS-1:0] wr_hi_c;
    logic [NUM_TIMERS-1:0] wr_ctrl_c;
    logic [NUM_TIMERS-1:0] force_c;
    logic [NUM_TIMERS-1:0] cnt_en_c;
    logic [NUM_TIMERS-1:0] uf_c;
    logic                  bus_c;
    logic                  icr_wr_c;
    logic                  icr_rd_c;

    function automatic logic [CNT_W-1:0] set_lo(input logic [CNT_W-1:0] v, input logic [7:0] d);
        return (v & ~CNT_W'(8'hFF)) | CNT_W'(d);
    endfunction

    function automatic logic [CNT_W-1:0] set_hi(input logic [CNT_W-1:0] v, input logic [7:0] d);
        return (v & CNT_W'(8'hFF)) | CNT_W'({d, 8'h00});
    endfunction

    // Bus decode and count events; a chained timer's event is its predecessor's underflow.
    always_comb begin
        logic carry;
        logic ev;
        logic sel;
        bus_c     = i_tick_en & i_cs;
        icr_wr_c  = bus_c & i_we & (i_addr == ICR_ADDR);
        icr_rd_c  = bus_c & ~i_we & (i_addr == ICR_ADDR);
        wr_lo_c   = '0;
        wr_hi_c   = '0;
        wr_ctrl_c = '0;
        force_c   = '0;
        cnt_en_c  = '0;
        uf_c      = '0;
        carry     = 1'b0;
        ev        = 1'b0;
        sel       = 1'b0;
        for (int unsigned n = 0; n < NUM_TIMERS; n++) begin
            sel          = bus_c & i_we & (i_addr[3:2] == 2'(n));
            wr_lo_c[n]   = sel & (i_addr[1:0] == 2'd0);
            wr_hi_c[n]   = sel & (i_addr[1:0] == 2'd1) & (CNT_W > 8);
            wr_ctrl_c[n] = sel & (i_addr[1:0] == 2'd2);
            force_c[n]   = wr_ctrl_c[n] & i_data[4];
            ev           = (n > 0 && chain_q[n]) ? carry : 1'b1;
            cnt_en_c[n]  = i_tick_en & start_q[n] & ev & ~force_c[n];
            uf_c[n]      = cnt_en_c[n] & (cnt_q[n] == '0);
            carry        = uf_c[n];
        end
    end

    // Counters, latches and run/mode bits; a CPU control write overrides one-shot auto-stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < NUM_TIMERS; n++) begin
                cnt_q[n] <= '1;
                lat_q[n] <= '1;
            end
            start_q   <= '0;
            oneshot_q <= '0;
        end else if (i_tick_en) begin
            for (int unsigned n = 0; n < NUM_TIMERS; n++) begin
                if (wr_lo_c[n]) lat_q[n] <= set_lo(lat_q[n], i_data);
                if (wr_hi_c[n]) lat_q[n] <= set_hi(lat_q[n], i_data);

                if (force_c[n])                      cnt_q[n] <= lat_q[n];
                else if (wr_hi_c[n] && !start_q[n])  cnt_q[n] <= set_hi(lat_q[n], i_data);
                else if (uf_c[n])                    cnt_q[n] <= lat_q[n];
                else if (cnt_en_c[n])                cnt_q[n] <= cnt_q[n] - CNT_W'(1);

                if (wr_ctrl_c[n]) begin
                    start_q[n]   <= i_data[0];
                    oneshot_q[n] <= i_data[3];
                end else if (uf_c[n] && oneshot_q[n]) begin
                    start_q[n]   <= 1'b0;
                end
            end
        end
    end

`ifdef CIA_TB_CHAIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else if (i_tick_en) begin
            for (int unsigned n = 0; n < NUM_TIMERS; n++) begin
                if (wr_ctrl_c[n]) chain_q[n] <= i_data[5];
            end
        end
    end
`else
    assign chain_q = '0;
`endif

    // ICR flags/mask; a same-tick underflow beats the read-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q      <= '0;
            mask_q      <= '0;
            o_irq       <= 1'b0;
            o_underflow <= '0;
        end else begin
            o_irq       <= |(flag_q & mask_q);
            o_underflow <= uf_c;
            if (i_tick_en) begin
                if (icr_wr_c) begin
                    mask_q <= i_data[7] ? (mask_q | i_data[NUM_TIMERS-1:0])
                                        : (mask_q & ~i_data[NUM_TIMERS-1:0]);
                end
                flag_q <= (icr_rd_c ? '0 : flag_q) | uf_c;
            end
        end
    end

    // Read mux, combinational from the address.
    always_comb begin
        o_data = '0;
        if (i_addr == ICR_ADDR) begin
            o_data[NUM_TIMERS-1:0] = flag_q;
            o_data[7]              = |(flag_q & mask_q);
        end else begin
            for (int unsigned n = 0; n < NUM_TIMERS; n++) begin
                if (i_addr[3:2] == 2'(n)) begin
                    case (i_addr[1:0])
                        2'd0:    o_data = cnt_q[n][7:0];
                        2'd1:    o_data = 8'(cnt_q[n] >> 8);
                        2'd2:    o_data = {2'b00, chain_q[n], 1'b0, oneshot_q[n], 2'b00, start_q[n]};
                        default: o_data = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/cia_timer_bank.md
# cia_timer_bank

Parametrised interval-timer bank for the C64 CIA path: up to three down-counters of configurable width, each one-shot or continuous, optional cascading, and a masked interrupt control register (ICR) with read-to-clear flags. Sits on the CPU bus behind a CIA chip-select, advances on the 1 MHz phase-1 enable, and drives the CPU IRQ line.

## Interface
- NUM_TIMERS, 2, number of timers (1..3)
- CNT_W, 16, counter/latch width in bits (8..16)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_tick_en  in  1  1 MHz phase-1 enable; qualifies counting and all bus accesses
- i_cs  in  1  chip select
- i_addr  in  4  register address
- i_we  in  1  write strobe
- i_data  in  8  write data
- o_data  out  8  read data, combinational from i_addr
- o_irq  out  1  interrupt request, active high
- o_underflow  out  NUM_TIMERS  per-timer underflow pulse

## Operation
- Register map, timer n at base 4n: +0 lo (write latch[7:0], read counter[7:0]); +1 hi (write latch[CNT_W-1:8], read counter[CNT_W-1:8], unused bits 0); +2 control; +3 reads 0. 0xD = ICR. Unmapped addresses and timers n >= NUM_TIMERS read 0, ignore writes.
- Bus access occurs only when i_tick_en & i_cs. CNT_W == 8: hi writes ignored, reads 0.
- Control bits: [0] START, [3] ONESHOT, [4] FORCE_LOAD (write-only strobe, reads 0), [5] CHAIN; other bits read 0.
- Count source: i_tick_en, or (CHAIN, n>0) underflow of timer n-1 in the same tick, combinationally.
- On a count event with START=1: counter==0 -> underflow: reload from latch, set ICR flag n, pulse o_underflow[n]; if ONESHOT, clear START. Otherwise decrement. Period = latch+1 events; latch 0 underflows on every event.
- Hi write while START=0 also loads counter from {new hi, lo latch}.
- FORCE_LOAD loads counter from latch that tick; no decrement or underflow that tick.
- ICR write: bit7=1 sets mask bits where data[k]=1, bit7=0 clears them. ICR read: bits[NUM_TIMERS-1:0] flags, bit7 = |(flags & mask); read clears all flags.
- o_irq = |(flags & mask), flags and mask being registers.
- Simultaneous: underflow and ICR read in the same tick -> that flag stays set. ONESHOT auto-stop and CPU control write in the same tick -> CPU write wins.
- Reset values: counters and latches all ones; control 0; mask 0; flags 0; o_irq 0; o_underflow 0.

## Timing
- All state updates on the clk edge where i_tick_en=1; nothing changes otherwise.
- Counter, flag and ICR-clear updates are visible on the edge ending the tick.
- o_irq rises one clk after the underflow edge (registered flag) and falls one clk after the clearing read or mask clear.
- o_underflow[n] is registered: high for exactly one clk after the underflow edge.
- Chained timer decrements on the same tick as the predecessor's underflow; no extra latency through the chain.
- rst_n assertion mid-count clears immediately, asynchronously; release synchronous to clk.

## Configuration
- CIA_TB_CHAIN_EN defined: CHAIN bit implemented as above.
- Undefined: CHAIN bit is not stored, reads 0, and all timers count i_tick_en only.

## Test plan
- Timer0 latch=0x0003, control=0x11 (START|FORCE_LOAD) -> counter 3,2,1,0,3; underflow every 4 ticks; o_underflow[0] is a 1-clk pulse.
- ONESHOT: latch=0x0002, control=0x19 -> single underflow after 3 ticks, START reads 0, counter holds at 2.
- ICR: write 0x81, run timer0 to underflow -> o_irq=1; read 0xD returns 0x81; o_irq=0 next clk; write 0x01 (clear mask) and underflow -> flag set, o_irq stays 0, read returns 0x01.
- Chain (CIA_TB_CHAIN_EN): timer0 latch=1, timer1 latch=2 CHAIN -> timer1 underflows every 6 ticks, same tick as timer0 underflow.
- Simultaneous: underflow on the same tick as an ICR read -> flag still set, o_irq remains 1.
- CNT_W=8: hi write ignored, hi reads 0x00; reset mid-count -> counters 0xFF, o_irq=0 immediately.
